// File: rtl/mac_op_sequencer.sv
// Command sequencer upstream of the bit-line controller: launches one cell operation,
// waits for bit-line bias, then drives the timed word-line pulse and reports done/timeout.
module mac_op_sequencer #(
  parameter int unsigned PULSE_W_WR = 20,
  parameter int unsigned PULSE_W_RD = 8,
  parameter int unsigned DOWN_LEAD  = 2,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [9:0] cmd_addr,
  input  logic       cmd_write,
  input  logic       cmd_set,
  output logic       work_en,
  output logic       work_mode,
  output logic       op_mode,
  output logic [4:0] bl_addr_in,
  output logic       op_down,
  input  logic       bl_assert_en,
  output logic [4:0] wl_addr,
  output logic       wl_pulse_en,
  output logic       busy,
  output logic       done,
  output logic       err_timeout
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LAUNCH  = 3'd1,
    ST_WAIT_BL = 3'd2,
    ST_PULSE   = 3'd3,
    ST_DRAIN   = 3'd4
  } state_t;

  localparam logic [7:0] W_WR_8    = 8'(PULSE_W_WR);
  localparam logic [7:0] W_RD_8    = 8'(PULSE_W_RD);
  localparam logic [7:0] LEAD_8    = 8'(DOWN_LEAD);
  localparam logic [7:0] TIMEOUT_8 = 8'(TIMEOUT);

  state_t     r_state;
  logic [7:0] r_tmo_cnt;
  logic [7:0] r_pulse_cnt;
  logic       r_work_en;
  logic       r_work_mode;
  logic       r_op_mode;
  logic [4:0] r_bl_addr;
  logic       r_op_down;
  logic [4:0] r_wl_addr;
  logic       r_wl_pulse_en;
  logic       r_done;
  logic       r_err_timeout;

  function automatic logic [7:0] pulse_width(input logic is_write);
    if (is_write) begin
      return W_WR_8;
    end else begin
      return W_RD_8;
    end
  endfunction

  function automatic logic in_down_zone(input logic [7:0] cnt);
    return (cnt <= LEAD_8);
  endfunction

  // Sequencer FSM; every datapath output is registered here.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_state       <= ST_IDLE;
      r_tmo_cnt     <= 8'd0;
      r_pulse_cnt   <= 8'd0;
      r_work_en     <= 1'b0;
      r_work_mode   <= 1'b0;
      r_op_mode     <= 1'b0;
      r_bl_addr     <= 5'd0;
      r_op_down     <= 1'b0;
      r_wl_addr     <= 5'd0;
      r_wl_pulse_en <= 1'b0;
      r_done        <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      r_work_en     <= 1'b0;
      r_done        <= 1'b0;
      r_err_timeout <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            r_bl_addr   <= cmd_addr[9:5];
            r_wl_addr   <= cmd_addr[4:0];
            r_work_mode <= cmd_write;
            r_op_mode   <= cmd_write & cmd_set;
            r_work_en   <= 1'b1;
            r_state     <= ST_LAUNCH;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_LAUNCH: begin
          r_tmo_cnt <= TIMEOUT_8;
          r_state   <= ST_WAIT_BL;
        end
        ST_WAIT_BL: begin
          // A zero count means the timeout strobe already went out last edge.
          if (r_tmo_cnt == 8'd0) begin
            r_state <= ST_IDLE;
          end else if (bl_assert_en) begin
            r_pulse_cnt   <= pulse_width(r_work_mode);
            r_wl_pulse_en <= 1'b1;
            r_op_down     <= in_down_zone(pulse_width(r_work_mode));
            r_state       <= ST_PULSE;
          end else begin
            r_tmo_cnt     <= r_tmo_cnt - 8'd1;
            r_err_timeout <= (r_tmo_cnt == 8'd1);
            r_state       <= ST_WAIT_BL;
          end
        end
        ST_PULSE: begin
          if (r_pulse_cnt <= 8'd1) begin
            r_wl_pulse_en <= 1'b0;
            r_op_down     <= 1'b0;
            r_done        <= 1'b1;
            r_state       <= ST_DRAIN;
          end else begin
            r_pulse_cnt <= r_pulse_cnt - 8'd1;
            r_op_down   <= in_down_zone(r_pulse_cnt - 8'd1);
            r_state     <= ST_PULSE;
          end
        end
        ST_DRAIN: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_wl_pulse_en <= 1'b0;
          r_op_down     <= 1'b0;
          r_state       <= ST_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready   = (r_state == ST_IDLE);
  assign busy        = (r_state != ST_IDLE);
  assign work_en     = r_work_en;
  assign work_mode   = r_work_mode;
  assign op_mode     = r_op_mode;
  assign bl_addr_in  = r_bl_addr;
  assign op_down     = r_op_down;
  assign wl_addr     = r_wl_addr;
  assign wl_pulse_en = r_wl_pulse_en;
  assign done        = r_done;
  assign err_timeout = r_err_timeout;

endmodule

// File: tb/tb_mac_op_sequencer.sv
// Directed bench for mac_op_sequencer: default-parameter instance (a_) plus a
// TIMEOUT=5 instance (b_) for the timeout and priority cases.
module tb_mac_op_sequencer;

  logic sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic       a_rst_n, a_cmd_valid, a_cmd_ready, a_cmd_write, a_cmd_set;
  logic [9:0] a_cmd_addr;
  logic       a_work_en, a_work_mode, a_op_mode, a_op_down, a_bl_assert_en;
  logic [4:0] a_bl_addr_in, a_wl_addr;
  logic       a_wl_pulse_en, a_busy, a_done, a_err_timeout;

  logic       b_rst_n, b_cmd_valid, b_cmd_ready, b_cmd_write, b_cmd_set;
  logic [9:0] b_cmd_addr;
  logic       b_work_en, b_work_mode, b_op_mode, b_op_down, b_bl_assert_en;
  logic [4:0] b_bl_addr_in, b_wl_addr;
  logic       b_wl_pulse_en, b_busy, b_done, b_err_timeout;

  mac_op_sequencer dut_a (
    .sys_clk(sys_clk), .sys_rst_n(a_rst_n),
    .cmd_valid(a_cmd_valid), .cmd_ready(a_cmd_ready), .cmd_addr(a_cmd_addr),
    .cmd_write(a_cmd_write), .cmd_set(a_cmd_set),
    .work_en(a_work_en), .work_mode(a_work_mode), .op_mode(a_op_mode),
    .bl_addr_in(a_bl_addr_in), .op_down(a_op_down), .bl_assert_en(a_bl_assert_en),
    .wl_addr(a_wl_addr), .wl_pulse_en(a_wl_pulse_en), .busy(a_busy),
    .done(a_done), .err_timeout(a_err_timeout)
  );

  mac_op_sequencer #(.TIMEOUT(5)) dut_b (
    .sys_clk(sys_clk), .sys_rst_n(b_rst_n),
    .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready), .cmd_addr(b_cmd_addr),
    .cmd_write(b_cmd_write), .cmd_set(b_cmd_set),
    .work_en(b_work_en), .work_mode(b_work_mode), .op_mode(b_op_mode),
    .bl_addr_in(b_bl_addr_in), .op_down(b_op_down), .bl_assert_en(b_bl_assert_en),
    .wl_addr(b_wl_addr), .wl_pulse_en(b_wl_pulse_en), .busy(b_busy),
    .done(b_done), .err_timeout(b_err_timeout)
  );

  int n_checks;
  int n_pass;
  int cyc;
  int lc;
  int a_work_n, a_work_first, a_work_cyc, a_pulse_n, a_pulse_first;
  int a_down_n, a_down_first, a_done_n, a_done_cyc, a_err_n;
  int b_pulse_n, b_done_n, b_err_n, b_err_cyc;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] a_outs();
    return {15'd0, a_work_en, a_work_mode, a_op_mode, a_bl_addr_in, a_op_down,
            a_wl_addr, a_wl_pulse_en, a_done, a_err_timeout};
  endfunction

  function automatic logic [31:0] b_outs();
    return {15'd0, b_work_en, b_work_mode, b_op_mode, b_bl_addr_in, b_op_down,
            b_wl_addr, b_wl_pulse_en, b_done, b_err_timeout};
  endfunction

  task automatic clr_mon();
    a_work_n = 0; a_work_first = -1; a_work_cyc = -1;
    a_pulse_n = 0; a_pulse_first = -1; a_down_n = 0; a_down_first = -1;
    a_done_n = 0; a_done_cyc = -1; a_err_n = 0;
    b_pulse_n = 0; b_done_n = 0; b_err_n = 0; b_err_cyc = -1;
  endtask

  // One clock edge, then sample the new cycle on the falling edge.
  task automatic cycle_step();
    @(posedge sys_clk);
    cyc++;
    @(negedge sys_clk);
    if (a_work_en) begin
      if (a_work_n == 0) a_work_first = cyc;
      a_work_n++;
      a_work_cyc = cyc;
    end
    if (a_wl_pulse_en) begin
      if (a_pulse_n == 0) a_pulse_first = cyc;
      a_pulse_n++;
    end
    if (a_op_down) begin
      if (a_down_n == 0) a_down_first = cyc;
      a_down_n++;
    end
    if (a_done) begin
      a_done_n++;
      a_done_cyc = cyc;
    end
    if (a_err_timeout) a_err_n++;
    if (b_wl_pulse_en) b_pulse_n++;
    if (b_done) b_done_n++;
    if (b_err_timeout) begin
      b_err_n++;
      b_err_cyc = cyc;
    end
  endtask

  task automatic launch_a(input logic [9:0] addr, input logic wr, input logic st);
    a_cmd_addr = addr; a_cmd_write = wr; a_cmd_set = st; a_cmd_valid = 1'b1;
    cycle_step();
    a_cmd_valid = 1'b0;
  endtask

  task automatic launch_b(input logic [9:0] addr, input logic wr, input logic st);
    b_cmd_addr = addr; b_cmd_write = wr; b_cmd_set = st; b_cmd_valid = 1'b1;
    cycle_step();
    b_cmd_valid = 1'b0;
  endtask

  initial begin
    n_checks = 0; n_pass = 0; cyc = 0; lc = 0;
    a_rst_n = 1'b0; a_cmd_valid = 1'b0; a_cmd_addr = 10'd0; a_cmd_write = 1'b0;
    a_cmd_set = 1'b0; a_bl_assert_en = 1'b0;
    b_rst_n = 1'b0; b_cmd_valid = 1'b0; b_cmd_addr = 10'd0; b_cmd_write = 1'b0;
    b_cmd_set = 1'b0; b_bl_assert_en = 1'b0;
    clr_mon();

    // Reset values
    repeat (3) cycle_step();
    a_rst_n = 1'b1; b_rst_n = 1'b1;
    cycle_step();
    check_val("rst_outs_a", a_outs(), 32'd0);
    check_val("rst_ready_a", 32'(a_cmd_ready), 32'd1);
    check_val("rst_busy_a", 32'(a_busy), 32'd0);
    check_val("rst_outs_b", b_outs(), 32'd0);
    check_val("rst_ready_b", 32'(b_cmd_ready), 32'd1);
    check_val("rst_busy_b", 32'(b_busy), 32'd0);

    // Write-set, bl_assert_en sampled at relative edge 21
    clr_mon();
    launch_a(10'h3A5, 1'b1, 1'b1);
    lc = cyc;
    check_val("wr_work_en", 32'(a_work_en), 32'd1);
    repeat (20) cycle_step();
    check_val("wr_wait_busy", 32'(a_busy), 32'd1);
    check_val("wr_bl_addr", 32'(a_bl_addr_in), 32'h1D);
    check_val("wr_wl_addr", 32'(a_wl_addr), 32'h05);
    check_val("wr_op_mode", 32'(a_op_mode), 32'd1);
    check_val("wr_work_mode", 32'(a_work_mode), 32'd1);
    a_bl_assert_en = 1'b1;
    cycle_step();
    a_bl_assert_en = 1'b0;
    repeat (21) cycle_step();
    check_val("wr_ready_back", 32'(a_cmd_ready), 32'd1);
    check_val("wr_pulse_n", 32'(a_pulse_n), 32'd20);
    check_val("wr_pulse_first", 32'(a_pulse_first), 32'(lc + 21));
    check_val("wr_down_n", 32'(a_down_n), 32'd2);
    check_val("wr_down_first", 32'(a_down_first), 32'(lc + 39));
    check_val("wr_done_n", 32'(a_done_n), 32'd1);
    check_val("wr_done_cyc", 32'(a_done_cyc), 32'(lc + 41));
    check_val("wr_work_n", 32'(a_work_n), 32'd1);
    check_val("wr_err_n", 32'(a_err_n), 32'd0);

    // Read with cmd_valid held high; stray bl_assert_en in PULSE
    clr_mon();
    a_cmd_addr = 10'h001; a_cmd_write = 1'b0; a_cmd_set = 1'b1; a_cmd_valid = 1'b1;
    for (int i = 0; i < 30; i++) begin
      cycle_step();
      if (a_work_n >= 2) a_cmd_valid = 1'b0;
      a_bl_assert_en = (a_work_n > 0) && ((cyc == a_work_cyc + 1) || (cyc == a_work_cyc + 4));
    end
    a_bl_assert_en = 1'b0;
    check_val("rd_accepts", 32'(a_work_n), 32'd2);
    check_val("rd_spacing", 32'(a_work_cyc - a_work_first), 32'd12);
    check_val("rd_pulse_first", 32'(a_pulse_first), 32'(a_work_first + 2));
    check_val("rd_pulse_n", 32'(a_pulse_n), 32'd16);
    check_val("rd_down_n", 32'(a_down_n), 32'd4);
    check_val("rd_done_n", 32'(a_done_n), 32'd2);
    check_val("rd_done_cyc", 32'(a_done_cyc), 32'(a_work_cyc + 10));
    check_val("rd_op_mode", 32'(a_op_mode), 32'd0);
    check_val("rd_work_mode", 32'(a_work_mode), 32'd0);
    check_val("rd_bl_addr", 32'(a_bl_addr_in), 32'h00);
    check_val("rd_wl_addr", 32'(a_wl_addr), 32'h01);

    // Stray bl_assert_en while idle
    clr_mon();
    a_bl_assert_en = 1'b1;
    repeat (3) cycle_step();
    a_bl_assert_en = 1'b0;
    cycle_step();
    check_val("idle_stray_busy", 32'(a_busy), 32'd0);
    check_val("idle_stray_pulse", 32'(a_pulse_n), 32'd0);

    // Reset in the 10th PULSE cycle, then a normal command
    clr_mon();
    launch_a(10'h2C7, 1'b1, 1'b0);
    cycle_step();
    check_val("mid_op_mode", 32'(a_op_mode), 32'd0);
    check_val("mid_bl_addr", 32'(a_bl_addr_in), 32'h16);
    check_val("mid_wl_addr", 32'(a_wl_addr), 32'h07);
    a_bl_assert_en = 1'b1;
    cycle_step();
    a_bl_assert_en = 1'b0;
    repeat (9) cycle_step();
    check_val("mid_pre_pulse", 32'(a_wl_pulse_en), 32'd1);
    a_rst_n = 1'b0;
    cycle_step();
    check_val("mid_rst_outs", a_outs(), 32'd0);
    check_val("mid_rst_busy", 32'(a_busy), 32'd0);
    a_rst_n = 1'b1;
    repeat (3) cycle_step();
    check_val("mid_pulse_n", 32'(a_pulse_n), 32'd10);
    check_val("mid_no_done", 32'(a_done_n), 32'd0);
    clr_mon();
    launch_a(10'h155, 1'b0, 1'b0);
    cycle_step();
    a_bl_assert_en = 1'b1;
    cycle_step();
    a_bl_assert_en = 1'b0;
    repeat (12) cycle_step();
    check_val("post_pulse_n", 32'(a_pulse_n), 32'd8);
    check_val("post_done_n", 32'(a_done_n), 32'd1);
    check_val("post_bl_addr", 32'(a_bl_addr_in), 32'h0A);
    check_val("post_wl_addr", 32'(a_wl_addr), 32'h15);
    check_val("post_ready", 32'(a_cmd_ready), 32'd1);

    // Timeout with TIMEOUT=5
    clr_mon();
    launch_b(10'h0AA, 1'b1, 1'b1);
    lc = cyc;
    repeat (6) cycle_step();
    check_val("to_err_strobe", 32'(b_err_timeout), 32'd1);
    check_val("to_not_ready", 32'(b_cmd_ready), 32'd0);
    cycle_step();
    check_val("to_ready_back", 32'(b_cmd_ready), 32'd1);
    check_val("to_err_clear", 32'(b_err_timeout), 32'd0);
    repeat (5) cycle_step();
    check_val("to_err_n", 32'(b_err_n), 32'd1);
    check_val("to_err_cyc", 32'(b_err_cyc), 32'(lc + 6));
    check_val("to_done_n", 32'(b_done_n), 32'd0);
    check_val("to_pulse_n", 32'(b_pulse_n), 32'd0);

    // bl_assert_en on the expiry edge wins
    clr_mon();
    launch_b(10'h3FF, 1'b0, 1'b1);
    repeat (5) cycle_step();
    b_bl_assert_en = 1'b1;
    cycle_step();
    b_bl_assert_en = 1'b0;
    check_val("prio_pulse", 32'(b_wl_pulse_en), 32'd1);
    check_val("prio_no_err", 32'(b_err_timeout), 32'd0);
    repeat (10) cycle_step();
    check_val("prio_err_n", 32'(b_err_n), 32'd0);
    check_val("prio_pulse_n", 32'(b_pulse_n), 32'd8);
    check_val("prio_done_n", 32'(b_done_n), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
